// File: rtl/sram_d_arbiter.sv
// Two-master round-robin OBI arbiter for the SRAM data port.
// An ID FIFO of issuing masters steers each in-order response back to its owner.
module sram_d_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             m0_req_i,
  output logic             m0_gnt_o,
  input  logic [31:0]      m0_addr_i,
  input  logic             m0_we_i,
  input  logic [3:0]       m0_be_i,
  input  logic [31:0]      m0_wdata_i,
  output logic             m0_rvalid_o,
  output logic [31:0]      m0_rdata_o,
  input  logic             m1_req_i,
  output logic             m1_gnt_o,
  input  logic [31:0]      m1_addr_i,
  input  logic             m1_we_i,
  input  logic [3:0]       m1_be_i,
  input  logic [31:0]      m1_wdata_i,
  output logic             m1_rvalid_o,
  output logic [31:0]      m1_rdata_o,
  output logic             s_req_o,
  input  logic             s_gnt_i,
  output logic [31:0]      s_addr_o,
  output logic             s_we_o,
  output logic [3:0]       s_be_o,
  output logic [31:0]      s_wdata_o,
  input  logic             s_rvalid_i,
  input  logic [31:0]      s_rdata_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             protocol_err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic             r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_occ;
  logic             r_last;
  logic             r_err;

  logic w_full;
  logic w_empty;
  logic w_sel;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_full  = (r_occ == CNT_W'(MAX_OUTSTANDING));
  assign w_empty = (r_occ == '0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_sel = 1'b0;
    if (m0_req_i && m1_req_i) begin
      w_sel = ~r_last;
    end else if (m1_req_i) begin
      w_sel = 1'b1;
    end
  end

  // With no requester, sel stays 0 so the slave sees M0's fields rather than X.
  assign s_req_o   = (m0_req_i | m1_req_i) & ~w_full;
  assign s_addr_o  = w_sel ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = w_sel ? m1_we_i    : m0_we_i;
  assign s_be_o    = w_sel ? m1_be_i    : m0_be_i;
  assign s_wdata_o = w_sel ? m1_wdata_i : m0_wdata_i;

  assign m0_gnt_o = s_gnt_i & s_req_o & ~w_sel;
  assign m1_gnt_o = s_gnt_i & s_req_o &  w_sel;

  assign w_push = s_req_o & s_gnt_i;
  assign w_pop  = s_rvalid_i & ~w_empty;
  assign w_head = r_fifo[r_rd_ptr];

  assign m0_rvalid_o = w_pop & ~w_head;
  assign m1_rvalid_o = w_pop &  w_head;
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

  assign outstanding_o  = r_occ;
  assign protocol_err_o = r_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_last   <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + 1'b1;
        r_last   <= w_sel;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (s_rvalid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  // NOTE: ID storage is not reset; the cleared pointers and occupancy make stale entries unreachable.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_sel;
    end
  end

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Directed testbench for sram_d_arbiter: arbitration, ID routing, back-pressure, errors, reset.
module tb_sram_d_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o, s_gnt_i, s_we_o, s_rvalid_i;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_be_o;
  logic [1:0]  outstanding_o;
  logic        protocol_err_o;

  int n_cmp = 0;
  int n_mis = 0;

  // {s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}
  logic [4:0] ctl;
  assign ctl = {s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o};

  always #5 clk_i = ~clk_i;

  sram_d_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
  );

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    m0_req_i = 1'b1; m1_req_i = 1'b1; s_gnt_i = 1'b1;
    apply_reset();
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    m0_addr_i = 32'h0000_0011; m1_addr_i = 32'h0000_0022;
    #1;
    if (outstanding_o !== 2'd0) begin n_mis++; $display("FAIL reset_occ: got %0d expected 0", outstanding_o); end
    n_cmp++;
    if (protocol_err_o !== 1'b0) begin n_mis++; $display("FAIL reset_err: got %b expected 0", protocol_err_o); end
    n_cmp++;
    if (ctl !== 5'b00000) begin n_mis++; $display("FAIL reset_ctl: got %b expected 00000", ctl); end
    n_cmp++;
    if (s_addr_o !== 32'h0000_0011) begin n_mis++; $display("FAIL idle_addr_m0: got %h expected 00000011", s_addr_o); end
    n_cmp++;
    tick();
  endtask

  task automatic test_single_read();
    m0_req_i = 1'b1; m0_addr_i = 32'h8000_0010; m0_we_i = 1'b0; m0_be_i = 4'hF;
    s_gnt_i = 1'b1; s_rvalid_i = 1'b0;
    #1;
    if (ctl !== 5'b11000) begin n_mis++; $display("FAIL single_gnt: got %b expected 11000", ctl); end
    n_cmp++;
    if (s_addr_o !== 32'h8000_0010) begin n_mis++; $display("FAIL single_addr: got %h expected 80000010", s_addr_o); end
    n_cmp++;
    tick();
    m0_req_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'hDEAD_BEEF;
    #1;
    if (outstanding_o !== 2'd1) begin n_mis++; $display("FAIL single_occ1: got %0d expected 1", outstanding_o); end
    n_cmp++;
    if (ctl !== 5'b00010) begin n_mis++; $display("FAIL single_rvalid: got %b expected 00010", ctl); end
    n_cmp++;
    if (m0_rdata_o !== 32'hDEAD_BEEF || m1_rdata_o !== 32'h0) begin
      n_mis++; $display("FAIL single_rdata: got m0=%h m1=%h expected DEADBEEF/00000000", m0_rdata_o, m1_rdata_o);
    end
    n_cmp++;
    tick();
    s_rvalid_i = 1'b0;
    #1;
    if (outstanding_o !== 2'd0) begin n_mis++; $display("FAIL single_occ0: got %0d expected 0", outstanding_o); end
    n_cmp++;
  endtask

  task automatic test_round_robin();
    logic [4:0]  exp_ctl;
    logic [31:0] exp_d;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      m0_req_i = (i < 4); m1_req_i = (i < 4); s_gnt_i = 1'b1;
      s_rvalid_i = (i > 0); s_rdata_i = 32'hA000_0000 + 32'(i);
      exp_ctl = 5'b00000;
      if (i < 4) exp_ctl[4:2] = (i % 2 == 0) ? 3'b110 : 3'b101;
      if (i > 0) exp_ctl[1:0] = ((i - 1) % 2 == 0) ? 2'b10 : 2'b01;
      exp_d = 32'hA000_0000 + 32'(i);
      #1;
      if (ctl !== exp_ctl) begin n_mis++; $display("FAIL rr_ctl[%0d]: got %b expected %b", i, ctl, exp_ctl); end
      n_cmp++;
      if (i > 0 && (m0_rdata_o | m1_rdata_o) !== exp_d) begin
        n_mis++; $display("FAIL rr_rdata[%0d]: got %h expected %h", i, m0_rdata_o | m1_rdata_o, exp_d);
      end
      if (i > 0) n_cmp++;
      if (outstanding_o !== ((i == 0) ? 2'd0 : 2'd1)) begin
        n_mis++; $display("FAIL rr_occ[%0d]: got %0d expected %0d", i, outstanding_o, (i == 0) ? 0 : 1);
      end
      n_cmp++;
      tick();
    end
    s_rvalid_i = 1'b0;
    #1;
    if (outstanding_o !== 2'd0) begin n_mis++; $display("FAIL rr_drain: got %0d expected 0", outstanding_o); end
    n_cmp++;
  endtask

  task automatic test_full_stall();
    // {m0_req/m1_req, rvalid, expected ctl, expected occupancy}
    logic [4:0] exp_ctl [7] = '{5'b11000, 5'b10100, 5'b00000, 5'b00010, 5'b11001, 5'b00010, 5'b00000};
    logic [1:0] exp_occ [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    logic       req_v   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       rv_v    [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      m0_req_i = req_v[i]; m1_req_i = req_v[i]; s_gnt_i = 1'b1;
      s_rvalid_i = rv_v[i]; s_rdata_i = 32'hB000_0000 + 32'(i);
      #1;
      if (ctl !== exp_ctl[i]) begin n_mis++; $display("FAIL full_ctl[%0d]: got %b expected %b", i, ctl, exp_ctl[i]); end
      n_cmp++;
      if (outstanding_o !== exp_occ[i]) begin
        n_mis++; $display("FAIL full_occ[%0d]: got %0d expected %0d", i, outstanding_o, exp_occ[i]);
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_write_m1();
    m0_req_i = 1'b0; m0_addr_i = 32'h1111_1111; m0_be_i = 4'hF; m0_wdata_i = 32'hFFFF_FFFF; m0_we_i = 1'b0;
    m1_req_i = 1'b1; m1_addr_i = 32'h8000_0404; m1_be_i = 4'b0110; m1_wdata_i = 32'h1234_5678; m1_we_i = 1'b1;
    s_gnt_i = 1'b1; s_rvalid_i = 1'b0;
    #1;
    if ({s_addr_o, s_be_o, s_wdata_o, s_we_o} !== {32'h8000_0404, 4'b0110, 32'h1234_5678, 1'b1}) begin
      n_mis++; $display("FAIL wr_fields: got %h/%b/%h/%b expected 80000404/0110/12345678/1", s_addr_o, s_be_o, s_wdata_o, s_we_o);
    end
    n_cmp++;
    if (ctl !== 5'b10100) begin n_mis++; $display("FAIL wr_gnt: got %b expected 10100", ctl); end
    n_cmp++;
    tick();
    m1_req_i = 1'b0; m1_we_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h0;
    #1;
    if (ctl !== 5'b00001) begin n_mis++; $display("FAIL wr_rvalid: got %b expected 00001", ctl); end
    n_cmp++;
    tick();
    s_rvalid_i = 1'b0;
  endtask

  task automatic test_protocol_err();
    s_rvalid_i = 1'b1; s_rdata_i = 32'hCAFE_F00D;
    #1;
    if (ctl !== 5'b00000 || (m0_rdata_o | m1_rdata_o) !== 32'h0) begin
      n_mis++; $display("FAIL perr_drop: got ctl %b rdata %h expected 00000/0", ctl, m0_rdata_o | m1_rdata_o);
    end
    n_cmp++;
    tick();
    s_rvalid_i = 1'b0;
    #1;
    if (protocol_err_o !== 1'b1) begin n_mis++; $display("FAIL perr_set: got %b expected 1", protocol_err_o); end
    n_cmp++;
    tick();
    tick();
    if (protocol_err_o !== 1'b1) begin n_mis++; $display("FAIL perr_sticky: got %b expected 1", protocol_err_o); end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    m0_req_i = 1'b1; m1_req_i = 1'b1; s_gnt_i = 1'b1;
    tick();
    tick();
    if (outstanding_o !== 2'd2) begin n_mis++; $display("FAIL mid_occ2: got %0d expected 2", outstanding_o); end
    n_cmp++;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    if (outstanding_o !== 2'd0 || protocol_err_o !== 1'b0) begin
      n_mis++; $display("FAIL mid_clear: got occ %0d err %b expected 0/0", outstanding_o, protocol_err_o);
    end
    n_cmp++;
    if (ctl !== 5'b11000) begin n_mis++; $display("FAIL mid_m0_first: got %b expected 11000", ctl); end
    n_cmp++;
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    apply_reset();
  endtask

  initial begin
    rst_i = 1'b1;
    m0_req_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = '0; m0_be_i = '0; m0_wdata_i = '0;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = '0; m1_be_i = '0; m1_wdata_i = '0;
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
    #1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_full_stall();
    test_write_m1();
    test_protocol_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
